// File: rtl/riscv_pkg.sv
// Shared decoder control types, opcode constants and register-usage helpers
// for the downstream control pipeline.
package riscv_pkg;

  typedef enum logic [1:0] {
    CT_NONE   = 2'b00,
    CT_BRANCH = 2'b01,
    CT_JAL    = 2'b10,
    CT_JALR   = 2'b11
  } ctrl_transfer_e;

  typedef struct packed {
    logic           alu_src;
    logic           wb_data_src;
    logic           reg_write;
    logic           mem_read;
    logic           mem_write;
    logic [1:0]     alu_op;
    ctrl_transfer_e ctrl_transfer;
  } ctrl_t;

  typedef struct packed {
    logic wb_data_src;
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic wb_data_src;
    logic reg_write;
  } wb_ctrl_t;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return opcode != JAL;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP) || (opcode == STORE) || (opcode == BRANCH);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard detection: load-use and redirect, plus the PC and
// IF/ID enables resolved by priority (stall > redirect > load-use).
module hazard_detect
  import riscv_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [6:0]            id_opcode,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  ctrl_transfer_e        ex_ctrl_transfer,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_redirect,
  input  logic                  mem_stall,
  output logic                  load_use,
  output logic                  redirect,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush
);

  logic raw_load_use;

  always_comb begin
    redirect     = ex_redirect && ex_valid && (ex_ctrl_transfer != CT_NONE);
    raw_load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                   ((uses_rs1(id_opcode) && (id_rs1 == ex_rd)) ||
                    (uses_rs2(id_opcode) && (id_rs2 == ex_rd)));
    // A redirect squashes the ID instruction, so its load-use is moot.
    load_use     = raw_load_use && !redirect;

    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    if (mem_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (redirect) begin
      if_id_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM and MEM/WB control registers with bubble insertion for
// load-use and redirect, global memory stall, and saturating hazard counters.
module ctrl_pipe
  import riscv_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            id_opcode,
  input  logic [8:0]            id_ctrl,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_redirect,
  input  logic                  mem_stall,
  output logic [8:0]            ex_ctrl,
  output logic                  ex_valid,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [3:0]            mem_ctrl,
  output logic                  mem_valid,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic [1:0]            wb_ctrl,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic [CNT_W-1:0]      load_use_cnt,
  output logic [CNT_W-1:0]      redirect_cnt
);

  ctrl_t                 id_ctrl_s;
  ctrl_t                 ex_ctrl_q, ex_ctrl_d;
  logic                  ex_valid_q, ex_valid_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  mem_ctrl_t             mem_ctrl_q, mem_ctrl_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
  wb_ctrl_t              wb_ctrl_q, wb_ctrl_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [CNT_W-1:0]      load_use_cnt_q, load_use_cnt_d;
  logic [CNT_W-1:0]      redirect_cnt_q, redirect_cnt_d;
  logic                  load_use, redirect;

  assign id_ctrl_s = ctrl_t'(id_ctrl);

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .id_opcode        (id_opcode),
    .id_valid         (id_valid),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .ex_valid         (ex_valid_q),
    .ex_mem_read      (ex_ctrl_q.mem_read),
    .ex_ctrl_transfer (ex_ctrl_q.ctrl_transfer),
    .ex_rd            (ex_rd_q),
    .ex_redirect      (ex_redirect),
    .mem_stall        (mem_stall),
    .load_use         (load_use),
    .redirect         (redirect),
    .pc_write         (pc_write),
    .if_id_write      (if_id_write),
    .if_id_flush      (if_id_flush)
  );

  always_comb begin
    ex_ctrl_d      = ex_ctrl_q;
    ex_valid_d     = ex_valid_q;
    ex_rd_d        = ex_rd_q;
    mem_ctrl_d     = mem_ctrl_q;
    mem_valid_d    = mem_valid_q;
    mem_rd_d       = mem_rd_q;
    wb_ctrl_d      = wb_ctrl_q;
    wb_valid_d     = wb_valid_q;
    wb_rd_d        = wb_rd_q;
    load_use_cnt_d = load_use_cnt_q;
    redirect_cnt_d = redirect_cnt_q;

    if (!mem_stall) begin
      wb_ctrl_d   = '{wb_data_src: mem_ctrl_q.wb_data_src,
                      reg_write:   mem_ctrl_q.reg_write};
      wb_valid_d  = mem_valid_q;
      wb_rd_d     = mem_rd_q;
      mem_ctrl_d  = '{wb_data_src: ex_ctrl_q.wb_data_src,
                      reg_write:   ex_ctrl_q.reg_write,
                      mem_read:    ex_ctrl_q.mem_read,
                      mem_write:   ex_ctrl_q.mem_write};
      mem_valid_d = ex_valid_q;
      mem_rd_d    = ex_rd_q;

      if (redirect || load_use || !id_valid) begin
        ex_ctrl_d  = CTRL_BUBBLE;
        ex_valid_d = 1'b0;
        ex_rd_d    = '0;
      end else begin
        ex_ctrl_d  = id_ctrl_s;
        ex_valid_d = 1'b1;
        ex_rd_d    = id_rd;
      end

      if (redirect && (redirect_cnt_q != '1))
        redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
      if (load_use && (load_use_cnt_q != '1))
        load_use_cnt_d = load_use_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl_q      <= CTRL_BUBBLE;
      ex_valid_q     <= 1'b0;
      ex_rd_q        <= '0;
      mem_ctrl_q     <= '0;
      mem_valid_q    <= 1'b0;
      mem_rd_q       <= '0;
      wb_ctrl_q      <= '0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      load_use_cnt_q <= '0;
      redirect_cnt_q <= '0;
    end else begin
      ex_ctrl_q      <= ex_ctrl_d;
      ex_valid_q     <= ex_valid_d;
      ex_rd_q        <= ex_rd_d;
      mem_ctrl_q     <= mem_ctrl_d;
      mem_valid_q    <= mem_valid_d;
      mem_rd_q       <= mem_rd_d;
      wb_ctrl_q      <= wb_ctrl_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      load_use_cnt_q <= load_use_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign ex_ctrl      = ex_ctrl_q;
  assign ex_valid     = ex_valid_q;
  assign ex_rd        = ex_rd_q;
  assign mem_ctrl     = mem_ctrl_q;
  assign mem_valid    = mem_valid_q;
  assign mem_rd       = mem_rd_q;
  assign wb_ctrl      = wb_ctrl_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign load_use_cnt = load_use_cnt_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed scenarios plus randomized traffic against a stage-array model of ctrl_pipe.
module tb_ctrl_pipe;

  localparam int RW = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [6:0] OPC_OP   = 7'b0110011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [8:0] C_OP     = 9'h044;  // reg_write, ALU_op=01
  localparam logic [8:0] C_LOAD   = 9'h1E0;  // ALU_src, WB_data_src, reg_write, mem_read
  localparam logic [8:0] C_JAL    = 9'h042;  // reg_write, transfer=JAL

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    id_opcode;
  logic [8:0]    id_ctrl;
  logic          id_valid;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic          ex_redirect, mem_stall;
  logic [8:0]    ex_ctrl;
  logic          ex_valid;
  logic [RW-1:0] ex_rd;
  logic [3:0]    mem_ctrl;
  logic          mem_valid;
  logic [RW-1:0] mem_rd;
  logic [1:0]    wb_ctrl;
  logic          wb_valid;
  logic [RW-1:0] wb_rd;
  logic          pc_write, if_id_write, if_id_flush;
  logic [CW-1:0] load_use_cnt, redirect_cnt;

  int checks = 0;
  int failures = 0;

  ctrl_pipe #(
    .REG_ADDR_W (RW),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_opcode    (id_opcode),
    .id_ctrl      (id_ctrl),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .ex_redirect  (ex_redirect),
    .mem_stall    (mem_stall),
    .ex_ctrl      (ex_ctrl),
    .ex_valid     (ex_valid),
    .ex_rd        (ex_rd),
    .mem_ctrl     (mem_ctrl),
    .mem_valid    (mem_valid),
    .mem_rd       (mem_rd),
    .wb_ctrl      (wb_ctrl),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .load_use_cnt (load_use_cnt),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [6:0] op, input logic [8:0] c,
                        input logic [RW-1:0] r1, input logic [RW-1:0] r2,
                        input logic [RW-1:0] rd);
    id_valid = v; id_opcode = op; id_ctrl = c;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd;
  endtask

  task automatic do_reset();
    reset = 1'b1; ex_redirect = 1'b0; mem_stall = 1'b0;
    set_id(1'b0, OPC_OP, '0, '0, '0, '0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({ex_valid, mem_valid, wb_valid} !== 3'b000) begin
      failures++; $display("FAIL reset_valids got=%b exp=000", {ex_valid, mem_valid, wb_valid});
    end
    checks++;
    if ({ex_ctrl, ex_rd, mem_ctrl, mem_rd, wb_ctrl, wb_rd} !== '0) begin
      failures++; $display("FAIL reset_fields got=%h exp=0", {ex_ctrl, ex_rd, mem_ctrl, mem_rd, wb_ctrl, wb_rd});
    end
    checks++;
    if ({load_use_cnt, redirect_cnt} !== '0) begin
      failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", load_use_cnt, redirect_cnt);
    end
  endtask

  task automatic test_pipeline();
    do_reset();
    set_id(1'b1, OPC_OP, C_OP, 5'd1, 5'd2, 5'd5);
    #1;
    checks++;
    if (pc_write !== 1'b1) begin failures++; $display("FAIL pipe_pc_write got=%b exp=1", pc_write); end
    tick();
    set_id(1'b0, OPC_OP, '0, '0, '0, '0);
    checks++;
    if ({ex_valid, ex_rd, ex_ctrl} !== {1'b1, 5'd5, C_OP}) begin
      failures++; $display("FAIL pipe_ex got=%b/%0d/%h exp=1/5/%h", ex_valid, ex_rd, ex_ctrl, C_OP);
    end
    tick();
    checks++;
    if ({mem_valid, mem_rd, mem_ctrl} !== {1'b1, 5'd5, 4'b0100}) begin
      failures++; $display("FAIL pipe_mem got=%b/%0d/%b exp=1/5/0100", mem_valid, mem_rd, mem_ctrl);
    end
    tick();
    checks++;
    if ({wb_valid, wb_rd, wb_ctrl} !== {1'b1, 5'd5, 2'b01}) begin
      failures++; $display("FAIL pipe_wb got=%b/%0d/%b exp=1/5/01", wb_valid, wb_rd, wb_ctrl);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, OPC_LOAD, C_LOAD, 5'd1, 5'd0, 5'd3);
    tick();
    set_id(1'b1, OPC_OP, C_OP, 5'd4, 5'd3, 5'd7);
    #1;
    checks++;
    if ({pc_write, if_id_write, if_id_flush} !== 3'b000) begin
      failures++; $display("FAIL lu_enables got=%b exp=000", {pc_write, if_id_write, if_id_flush});
    end
    tick();
    checks++;
    if ({ex_valid, mem_valid, mem_rd, load_use_cnt} !== {1'b0, 1'b1, 5'd3, 4'd1}) begin
      failures++; $display("FAIL lu_bubble got=%b/%b/%0d/%0d exp=0/1/3/1", ex_valid, mem_valid, mem_rd, load_use_cnt);
    end
    checks++;
    if ({pc_write, if_id_write} !== 2'b11) begin
      failures++; $display("FAIL lu_release got=%b exp=11", {pc_write, if_id_write});
    end
    tick();
    set_id(1'b0, OPC_OP, '0, '0, '0, '0);
    checks++;
    if ({ex_valid, ex_rd, load_use_cnt} !== {1'b1, 5'd7, 4'd1}) begin
      failures++; $display("FAIL lu_advance got=%b/%0d/%0d exp=1/7/1", ex_valid, ex_rd, load_use_cnt);
    end
  endtask

  task automatic test_load_rd0();
    do_reset();
    set_id(1'b1, OPC_LOAD, C_LOAD, 5'd1, 5'd0, 5'd0);
    tick();
    set_id(1'b1, OPC_OP, C_OP, 5'd0, 5'd0, 5'd7);
    #1;
    checks++;
    if (pc_write !== 1'b1) begin failures++; $display("FAIL rd0_pc_write got=%b exp=1", pc_write); end
    tick();
    set_id(1'b0, OPC_OP, '0, '0, '0, '0);
    checks++;
    if ({ex_valid, ex_rd, load_use_cnt} !== {1'b1, 5'd7, 4'd0}) begin
      failures++; $display("FAIL rd0_advance got=%b/%0d/%0d exp=1/7/0", ex_valid, ex_rd, load_use_cnt);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    // EX entry marks both a load and a transfer so register match would otherwise stall
    set_id(1'b1, OPC_JAL, C_JAL | 9'h020, 5'd0, 5'd0, 5'd1);
    tick();
    set_id(1'b1, OPC_LOAD, C_LOAD, 5'd1, 5'd0, 5'd9);
    ex_redirect = 1'b1;
    #1;
    checks++;
    if ({pc_write, if_id_write, if_id_flush} !== 3'b111) begin
      failures++; $display("FAIL redir_enables got=%b exp=111", {pc_write, if_id_write, if_id_flush});
    end
    tick();
    ex_redirect = 1'b0;
    set_id(1'b0, OPC_OP, '0, '0, '0, '0);
    checks++;
    if ({ex_valid, mem_valid, mem_ctrl[2], mem_rd} !== {1'b0, 1'b1, 1'b1, 5'd1}) begin
      failures++; $display("FAIL redir_stage got=%b/%b/%b/%0d exp=0/1/1/1", ex_valid, mem_valid, mem_ctrl[2], mem_rd);
    end
    checks++;
    if ({redirect_cnt, load_use_cnt} !== {4'd1, 4'd0}) begin
      failures++; $display("FAIL redir_counters got=%0d/%0d exp=1/0", redirect_cnt, load_use_cnt);
    end
    // redirect with no transfer in EX is ignored
    ex_redirect = 1'b1;
    #1;
    checks++;
    if (if_id_flush !== 1'b0) begin failures++; $display("FAIL redir_ignored got=%b exp=0", if_id_flush); end
    ex_redirect = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    set_id(1'b1, OPC_JAL, C_JAL, 5'd0, 5'd0, 5'd2);
    tick();
    set_id(1'b1, OPC_OP, C_OP, 5'd2, 5'd2, 5'd6);
    ex_redirect = 1'b1;
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({pc_write, if_id_write, if_id_flush} !== 3'b000) begin
        failures++; $display("FAIL stall_enables cyc=%0d got=%b exp=000", i, {pc_write, if_id_write, if_id_flush});
      end
      tick();
      checks++;
      if ({ex_valid, ex_rd, ex_ctrl, mem_valid, wb_valid, redirect_cnt} !== {1'b1, 5'd2, C_JAL, 1'b0, 1'b0, 4'd0}) begin
        failures++; $display("FAIL stall_frozen cyc=%0d got=%b/%0d/%h/%b/%b/%0d exp=1/2/%h/0/0/0",
                             i, ex_valid, ex_rd, ex_ctrl, mem_valid, wb_valid, redirect_cnt, C_JAL);
      end
    end
    mem_stall = 1'b0;
    #1;
    checks++;
    if (if_id_flush !== 1'b1) begin failures++; $display("FAIL stall_release_flush got=%b exp=1", if_id_flush); end
    tick();
    ex_redirect = 1'b0;
    set_id(1'b0, OPC_OP, '0, '0, '0, '0);
    checks++;
    if ({ex_valid, mem_valid, mem_rd, redirect_cnt} !== {1'b0, 1'b1, 5'd2, 4'd1}) begin
      failures++; $display("FAIL stall_release got=%b/%b/%0d/%0d exp=0/1/2/1", ex_valid, mem_valid, mem_rd, redirect_cnt);
    end
    tick();
    checks++;
    if (redirect_cnt !== 4'd1) begin failures++; $display("FAIL stall_once got=%0d exp=1", redirect_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < (1 << CW) + 5; i++) begin
      set_id(1'b1, OPC_LOAD, C_LOAD, 5'd0, 5'd0, 5'd3);
      tick();
      set_id(1'b1, OPC_OP, C_OP, 5'd3, 5'd1, 5'd4);
      tick();
    end
    checks++;
    if (load_use_cnt !== CW'(CMAX)) begin
      failures++; $display("FAIL sat_load_use got=%0d exp=%0d", load_use_cnt, CMAX);
    end
    set_id(1'b1, OPC_LOAD, C_LOAD, 5'd0, 5'd0, 5'd3);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({ex_valid, mem_valid, wb_valid, load_use_cnt, redirect_cnt} !== '0) begin
      failures++; $display("FAIL sat_midreset got=%b%b%b/%0d/%0d exp=000/0/0",
                           ex_valid, mem_valid, wb_valid, load_use_cnt, redirect_cnt);
    end
  endtask

  function automatic bit m_rs1(input logic [6:0] op);
    return op != OPC_JAL;
  endfunction

  function automatic bit m_rs2(input logic [6:0] op);
    return op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
  endfunction

  task automatic test_random();
    logic [6:0] opcodes [7];
    logic       mv [3];
    logic [8:0] mc [3];
    logic [4:0] mrd [3];
    int         mlu, mrc;
    bit         redir, lu, exp_pc;
    opcodes = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                7'b1100011, 7'b1101111, 7'b1100111};
    do_reset();
    for (int s = 0; s < 3; s++) begin mv[s] = 0; mc[s] = '0; mrd[s] = '0; end
    mlu = 0; mrc = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      reset       = ($urandom_range(0, 99) == 0);
      mem_stall   = ($urandom_range(0, 99) < 15);
      ex_redirect = ($urandom_range(0, 99) < 25);
      set_id($urandom_range(0, 9) < 8, opcodes[$urandom_range(0, 6)], 9'($urandom),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      #1;
      redir  = ex_redirect && mv[0] && (mc[0][1:0] != 2'b00);
      lu     = !redir && mv[0] && mc[0][5] && (mrd[0] != 0) && id_valid &&
               ((m_rs1(id_opcode) && id_rs1 == mrd[0]) || (m_rs2(id_opcode) && id_rs2 == mrd[0]));
      exp_pc = !mem_stall && !lu;
      checks++;
      if ({pc_write, if_id_write, if_id_flush} !== {exp_pc, exp_pc, !mem_stall && redir}) begin
        failures++; $display("FAIL rnd_enables cyc=%0d got=%b exp=%b", cyc,
                             {pc_write, if_id_write, if_id_flush}, {exp_pc, exp_pc, !mem_stall && redir});
      end
      checks++;
      if ({ex_valid, ex_rd, ex_ctrl} !== {mv[0], mrd[0], mc[0]}) begin
        failures++; $display("FAIL rnd_ex cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", cyc, ex_valid, ex_rd, ex_ctrl, mv[0], mrd[0], mc[0]);
      end
      checks++;
      if ({mem_valid, mem_rd, mem_ctrl} !== {mv[1], mrd[1], mc[1][7:4]}) begin
        failures++; $display("FAIL rnd_mem cyc=%0d got=%b/%0d/%b exp=%b/%0d/%b", cyc, mem_valid, mem_rd, mem_ctrl, mv[1], mrd[1], mc[1][7:4]);
      end
      checks++;
      if ({wb_valid, wb_rd, wb_ctrl} !== {mv[2], mrd[2], mc[2][7:6]}) begin
        failures++; $display("FAIL rnd_wb cyc=%0d got=%b/%0d/%b exp=%b/%0d/%b", cyc, wb_valid, wb_rd, wb_ctrl, mv[2], mrd[2], mc[2][7:6]);
      end
      checks++;
      if ({load_use_cnt, redirect_cnt} !== {CW'(mlu), CW'(mrc)}) begin
        failures++; $display("FAIL rnd_counters cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, load_use_cnt, redirect_cnt, mlu, mrc);
      end
      if (reset) begin
        for (int s = 0; s < 3; s++) begin mv[s] = 0; mc[s] = '0; mrd[s] = '0; end
        mlu = 0; mrc = 0;
      end else if (!mem_stall) begin
        for (int s = 2; s > 0; s--) begin mv[s] = mv[s-1]; mc[s] = mc[s-1]; mrd[s] = mrd[s-1]; end
        if (redir || lu || !id_valid) begin
          mv[0] = 0; mc[0] = '0; mrd[0] = '0;
        end else begin
          mv[0] = 1; mc[0] = id_ctrl; mrd[0] = id_rd;
        end
        if (redir && mrc < CMAX) mrc++;
        if (lu && mlu < CMAX) mlu++;
      end
      tick();
    end
    reset = 1'b0; mem_stall = 1'b0; ex_redirect = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pipeline();
    test_load_use();
    test_load_rd0();
    test_redirect();
    test_stall();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
